// File: rtl/arp_ctrl_if.sv
// ============================================================================
// Module      : arp_ctrl_if
// Description : Bus bundle between the ARP sequencer and its neighbours
//               (RX parser, MMIO register file, ARP transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arp_ctrl_if;
    logic        rx_req_valid;
    logic        rx_reply_valid;
    logic [47:0] rx_src_mac;
    logic [31:0] rx_src_ip;
    logic        req_start;
    logic [31:0] req_ip;
    logic        resolve_busy;
    logic        resolve_done;
    logic        resolve_fail;
    logic [47:0] resolved_mac;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] dest_mac;
    logic [31:0] dest_ip;
    logic        tx_done;

    modport master (
        output rx_req_valid, rx_reply_valid, rx_src_mac, rx_src_ip,
               req_start, req_ip, tx_done,
        input  resolve_busy, resolve_done, resolve_fail, resolved_mac,
               arp_tx_en, arp_tx_type, dest_mac, dest_ip
    );

    modport slave (
        input  rx_req_valid, rx_reply_valid, rx_src_mac, rx_src_ip,
               req_start, req_ip, tx_done,
        output resolve_busy, resolve_done, resolve_fail, resolved_mac,
               arp_tx_en, arp_tx_type, dest_mac, dest_ip
    );
endinterface

`default_nettype wire

// File: rtl/arp_ctrl.sv
// ============================================================================
// Module      : arp_ctrl
// Description : ARP transmit sequencer - auto-reply slot, broadcast resolve
//               with timed retries. Macro ARP_CTRL_AUTOREPLY_EN builds the
//               auto-reply slot; without it incoming requests are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_ctrl #(
    parameter int RETRY_CYCLES = 125_000_000,
    parameter int MAX_TRIES    = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    arp_ctrl_if.slave   bus
);

    localparam int            c_TW         = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(RETRY_CYCLES - 1);
    localparam logic [3:0]    c_MAX_TRIES  = 4'(MAX_TRIES);
    localparam logic [47:0]   c_BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT}  r_state_e;
    typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_GAP} t_state_e;

    r_state_e         r_state_q;
    t_state_e         t_state_q;
    logic [31:0]      target_ip_q;
    logic [3:0]       try_q;
    logic [c_TW-1:0]  timer_q;
    logic             req_pend_q;
    logic             req_inflight_q;
    logic             busy_q, done_q, fail_q;
    logic [47:0]      resolved_mac_q;
    logic [1:0]       gap_q;
    logic             tx_en_q, tx_type_q;
    logic [47:0]      dest_mac_q;
    logic [31:0]      dest_ip_q;

    logic             w_reply_pend;
    logic [47:0]      w_slot_mac;
    logic [31:0]      w_slot_ip;
    logic             w_launch_slot, w_launch_reply, w_launch_req;
    logic             w_tx_done, w_match;

    // The last gap cycle doubles as an idle decision point so the next rise
    // can land 4 cycles after tx_done.
    assign w_launch_slot  = (t_state_q == T_IDLE) || ((t_state_q == T_GAP) && (gap_q == 2'd2));
    assign w_launch_reply = w_launch_slot && w_reply_pend;
    assign w_launch_req   = w_launch_slot && !w_reply_pend && req_pend_q;
    assign w_tx_done      = bus.tx_done && (t_state_q == T_LAUNCH);
    assign w_match        = bus.rx_reply_valid && (bus.rx_src_ip == target_ip_q);

`ifdef ARP_CTRL_AUTOREPLY_EN
    logic        reply_pend_q;
    logic [47:0] slot_mac_q;
    logic [31:0] slot_ip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_pend_q <= 1'b0;
            slot_mac_q   <= '0;
            slot_ip_q    <= '0;
        end else begin
            if (w_launch_reply) reply_pend_q <= 1'b0;
            if (bus.rx_req_valid) begin
                reply_pend_q <= 1'b1;
                slot_mac_q   <= bus.rx_src_mac;
                slot_ip_q    <= bus.rx_src_ip;
            end
        end
    end

    assign w_reply_pend = reply_pend_q;
    assign w_slot_mac   = slot_mac_q;
    assign w_slot_ip    = slot_ip_q;
`else
    assign w_reply_pend = 1'b0;
    assign w_slot_mac   = '0;
    assign w_slot_ip    = '0;
`endif

    // Resolver FSM; also owns req_pend since both FSMs touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= R_IDLE;
            target_ip_q    <= '0;
            try_q          <= '0;
            timer_q        <= '0;
            req_pend_q     <= 1'b0;
            req_inflight_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            resolved_mac_q <= '0;
        end else begin
            if (w_launch_req) begin
                req_pend_q     <= 1'b0;
                req_inflight_q <= 1'b1;
            end
            if (w_tx_done) req_inflight_q <= 1'b0;

            case (r_state_q)
                R_IDLE: begin
                    if (bus.req_start) begin
                        target_ip_q <= bus.req_ip;
                        try_q       <= '0;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        req_pend_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        r_state_q   <= R_SEND;
                    end
                end
                R_SEND, R_WAIT: begin
                    if (w_match) begin
                        // In-flight frame finishes on its own; clearing the
                        // inflight flag keeps its tx_done from being counted.
                        resolved_mac_q <= bus.rx_src_mac;
                        done_q         <= 1'b1;
                        busy_q         <= 1'b0;
                        req_pend_q     <= 1'b0;
                        req_inflight_q <= 1'b0;
                        r_state_q      <= R_IDLE;
                    end else if (r_state_q == R_SEND) begin
                        if (w_tx_done && req_inflight_q) begin
                            try_q     <= try_q + 4'd1;
                            timer_q   <= '0;
                            r_state_q <= R_WAIT;
                        end
                    end else if (timer_q == c_TIMER_LAST) begin
                        if (try_q < c_MAX_TRIES) begin
                            req_pend_q <= 1'b1;
                            r_state_q  <= R_SEND;
                        end else begin
                            fail_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            r_state_q <= R_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // TX FSM; frame fields are frozen from launch until tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state_q  <= T_IDLE;
            gap_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_type_q  <= 1'b0;
            dest_mac_q <= '0;
            dest_ip_q  <= '0;
        end else begin
            case (t_state_q)
                T_LAUNCH: begin
                    if (bus.tx_done) begin
                        tx_en_q   <= 1'b0;
                        gap_q     <= '0;
                        t_state_q <= T_GAP;
                    end
                end
                T_IDLE, T_GAP: begin
                    if (t_state_q == T_GAP) begin
                        gap_q <= gap_q + 2'd1;
                        if (gap_q == 2'd2) t_state_q <= T_IDLE;
                    end
                    if (w_launch_reply) begin
                        tx_en_q    <= 1'b1;
                        tx_type_q  <= 1'b1;
                        dest_mac_q <= w_slot_mac;
                        dest_ip_q  <= w_slot_ip;
                        t_state_q  <= T_LAUNCH;
                    end else if (w_launch_req) begin
                        tx_en_q    <= 1'b1;
                        tx_type_q  <= 1'b0;
                        dest_mac_q <= c_BCAST_MAC;
                        dest_ip_q  <= target_ip_q;
                        t_state_q  <= T_LAUNCH;
                    end
                end
                default: t_state_q <= T_IDLE;
            endcase
        end
    end

    assign bus.resolve_busy = busy_q;
    assign bus.resolve_done = done_q;
    assign bus.resolve_fail = fail_q;
    assign bus.resolved_mac = resolved_mac_q;
    assign bus.arp_tx_en    = tx_en_q;
    assign bus.arp_tx_type  = tx_type_q;
    assign bus.dest_mac     = dest_mac_q;
    assign bus.dest_ip      = dest_ip_q;

endmodule

`default_nettype wire
